// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM state types for the APB UART.
package uart_pkg;

  localparam logic [1:0] REG_USR  = 2'd0;
  localparam logic [1:0] REG_UWD  = 2'd1;
  localparam logic [1:0] REG_URD  = 2'd2;
  localparam logic [1:0] REG_UCLR = 2'd3;

  localparam int USR_RX_VALID = 0;
  localparam int USR_TX_FULL  = 1;
  localparam int USR_TX_BUSY  = 2;
  localparam int USR_OVERRUN  = 3;

  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  // Oversampling divider; clamped so a too-fast baud still yields a tick every cycle.
  function automatic int baudDiv(input int clkHz, input int baud);
    int div;
    div = clkHz / (baud * TICKS_PER_BIT);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO; a pop and a push in the same cycle are both honoured even when full.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_rdata  = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/apb_uart.sv
// APB slave UART: status/data/clear registers, TX and RX FIFOs, 16x oversampled 8N1 serial FSMs.
module apb_uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx
);

  localparam int DIV   = baudDiv(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] r_baudCnt;
  logic             w_tick;

  logic       w_access, w_txPush, w_rxPop, w_clrOverrun;
  logic [1:0] w_addr;
  logic       w_unused;

  logic [7:0] w_txRdata, w_rxRdata;
  logic       w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
  logic       w_txPop, w_rxIn, w_rxStopSample, w_rxPushReq;

  txState_t   r_txState;
  logic       r_tx;
  logic [7:0] r_txShift;
  logic [3:0] r_txTickCnt;
  logic [2:0] r_txBitCnt;

  rxState_t   r_rxState;
  logic [1:0] r_rxSync;
  logic [7:0] r_rxShift;
  logic [3:0] r_rxTickCnt;
  logic [2:0] r_rxBitCnt;
  logic       r_overrun;

  assign w_access     = PSEL & PENABLE;
  assign w_addr       = PADDR[3:2];
  assign w_txPush     = w_access & PWRITE & (w_addr == REG_UWD);
  assign w_rxPop      = w_access & ~PWRITE & (w_addr == REG_URD);
  assign w_clrOverrun = w_access & PWRITE & (w_addr == REG_UCLR) & PWDATA[0];
  assign w_unused     = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8]};

  assign PREADY = w_access;
  assign tx     = r_tx;

  always_comb begin
    PRDATA = '0;
    if (w_access && !PWRITE) begin
      case (w_addr)
        REG_USR: begin
          PRDATA[USR_RX_VALID] = !w_rxEmpty;
          PRDATA[USR_TX_FULL]  = w_txFull;
          PRDATA[USR_TX_BUSY]  = (r_txState != TX_IDLE) || !w_txEmpty;
          PRDATA[USR_OVERRUN]  = r_overrun;
        end
        REG_URD: if (!w_rxEmpty) PRDATA[7:0] = w_rxRdata;
        default: ;
      endcase
    end
  end

  assign w_tick = (r_baudCnt == DIV_W'(DIV - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)      r_baudCnt <= '0;
    else if (w_tick) r_baudCnt <= '0;
    else             r_baudCnt <= r_baudCnt + DIV_W'(1);
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_push  (w_txPush),
    .i_pop   (w_txPop),
    .i_wdata (PWDATA[7:0]),
    .o_rdata (w_txRdata),
    .o_full  (w_txFull),
    .o_empty (w_txEmpty)
  );

  assign w_txPop = (r_txState == TX_IDLE) && w_tick && !w_txEmpty;

  // Each serial bit lasts 16 ticks; r_tx is updated on the edge that enters the next bit.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_txState   <= TX_IDLE;
      r_tx        <= 1'b1;
      r_txShift   <= '0;
      r_txTickCnt <= '0;
      r_txBitCnt  <= '0;
    end else if (w_tick) begin
      case (r_txState)
        TX_IDLE: begin
          if (!w_txEmpty) begin
            r_txShift   <= w_txRdata;
            r_tx        <= 1'b0;
            r_txTickCnt <= '0;
            r_txState   <= TX_START;
          end
        end
        TX_START: begin
          if (r_txTickCnt == 4'd15) begin
            r_txTickCnt <= '0;
            r_txBitCnt  <= '0;
            r_tx        <= r_txShift[0];
            r_txState   <= TX_DATA;
          end else begin
            r_txTickCnt <= r_txTickCnt + 4'd1;
          end
        end
        TX_DATA: begin
          if (r_txTickCnt == 4'd15) begin
            r_txTickCnt <= '0;
            if (r_txBitCnt == 3'd7) begin
              r_tx      <= 1'b1;
              r_txState <= TX_STOP;
            end else begin
              r_txBitCnt <= r_txBitCnt + 3'd1;
              r_txShift  <= {1'b0, r_txShift[7:1]};
              r_tx       <= r_txShift[1];
            end
          end else begin
            r_txTickCnt <= r_txTickCnt + 4'd1;
          end
        end
        TX_STOP: begin
          if (r_txTickCnt == 4'd15) begin
            r_txTickCnt <= '0;
            r_txState   <= TX_IDLE;
          end else begin
            r_txTickCnt <= r_txTickCnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_rxSync <= 2'b11;
    else        r_rxSync <= {r_rxSync[0], rx};
  end

  assign w_rxIn         = r_rxSync[1];
  assign w_rxStopSample = (r_rxState == RX_STOP) && w_tick && (r_rxTickCnt == 4'd15);
  assign w_rxPushReq    = w_rxStopSample && w_rxIn;

  // Start edge is confirmed half a bit in, so every later sample lands at a bit centre.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rxState   <= RX_IDLE;
      r_rxShift   <= '0;
      r_rxTickCnt <= '0;
      r_rxBitCnt  <= '0;
    end else begin
      case (r_rxState)
        RX_IDLE: begin
          if (!w_rxIn) begin
            r_rxTickCnt <= '0;
            r_rxState   <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rxTickCnt == 4'd7) begin
              r_rxTickCnt <= '0;
              r_rxBitCnt  <= '0;
              r_rxState   <= w_rxIn ? RX_IDLE : RX_DATA;
            end else begin
              r_rxTickCnt <= r_rxTickCnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rxTickCnt == 4'd15) begin
              r_rxTickCnt <= '0;
              r_rxShift   <= {w_rxIn, r_rxShift[7:1]};
              if (r_rxBitCnt == 3'd7) r_rxState <= RX_STOP;
              else                    r_rxBitCnt <= r_rxBitCnt + 3'd1;
            end else begin
              r_rxTickCnt <= r_rxTickCnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rxTickCnt == 4'd15) begin
              r_rxTickCnt <= '0;
              r_rxState   <= RX_IDLE;
            end else begin
              r_rxTickCnt <= r_rxTickCnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxFifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_push  (w_rxPushReq),
    .i_pop   (w_rxPop),
    .i_wdata (r_rxShift),
    .o_rdata (w_rxRdata),
    .o_full  (w_rxFull),
    .o_empty (w_rxEmpty)
  );

  // A lost byte outranks a clear landing on the same edge, so the event is never missed.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                        r_overrun <= 1'b0;
    else if (w_rxPushReq && w_rxFull && !w_rxPop)      r_overrun <= 1'b1;
    else if (w_clrOverrun)                             r_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_apb_uart.sv
// Scoreboard bench for apb_uart: TX frames decoded by a line monitor, RX bytes checked on URD reads.
module tb_apb_uart;

  localparam int CLK_HZ     = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CYC    = 16;

  localparam logic [31:0] A_USR  = 32'h1000_4000;
  localparam logic [31:0] A_UWD  = 32'h1000_4004;
  localparam logic [31:0] A_URD  = 32'h1000_4008;
  localparam logic [31:0] A_UCLR = 32'h1000_400C;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        rx;

  int         testCount = 0;
  int         failCount = 0;
  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];
  logic       expOverrun = 1'b0;
  logic       txMonEn = 1'b0;
  logic [31:0] rd;
  logic        rdy;
  int          lat;

  apb_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx),
    .rx      (rx)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [31:0] addr, output logic [31:0] data, output logic ready);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    data  = PRDATA;
    ready = PREADY;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    apbRead(addr, d, r);
    checkOutput(tag, d, exp);
  endtask

  // Drives one 8N1 frame on rx; the model predicts whether the byte lands or overruns.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    if (stopBit) begin
      if (rxExpQ.size() < FIFO_DEPTH) rxExpQ.push_back(b);
      else                            expOverrun = 1'b1;
    end
    @(negedge PCLK);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge PCLK);
    end
    rx = stopBit;
    repeat (BIT_CYC) @(negedge PCLK);
    rx = 1'b1;
  endtask

  task automatic readRxByte();
    logic [31:0] d;
    logic        r;
    apbRead(A_URD, d, r);
    checkOutput("rxQueueDepth", 32'(rxExpQ.size() > 0), 32'd1);
    if (rxExpQ.size() > 0) checkOutput("rxData", d, {24'h0, rxExpQ.pop_front()});
  endtask

  function automatic logic [31:0] expUsrRx();
    return {28'h0, expOverrun, 2'b00, rxExpQ.size() != 0};
  endfunction

  task automatic waitTxDrain(input int budget);
    int n = 0;
    while (txExpQ.size() != 0 && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput("txDrain", 32'(txExpQ.size()), 32'd0);
  endtask

  // Line monitor: samples each bit at its centre and scores the decoded frame.
  initial begin : txMonitor
    logic       startB, stopB;
    logic [7:0] got;
    forever begin
      wait (txMonEn);
      @(negedge tx);
      repeat (BIT_CYC / 2) @(negedge PCLK);
      startB = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(negedge PCLK);
        got[i] = tx;
      end
      repeat (BIT_CYC) @(negedge PCLK);
      stopB = tx;
      checkOutput("txStartBit", 32'(startB), 32'd0);
      checkOutput("txStopBit", 32'(stopB), 32'd1);
      checkOutput("txQueueDepth", 32'(txExpQ.size() > 0), 32'd1);
      if (txExpQ.size() > 0) checkOutput("txData", 32'(got), 32'(txExpQ.pop_front()));
    end
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; rx = 1'b1;
    #1;
    checkOutput("rstPready", 32'(PREADY), 32'd0);
    checkOutput("rstPrdata", PRDATA, 32'd0);
    checkOutput("rstTx", 32'(tx), 32'd1);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    apbRead(A_USR, rd, rdy);
    checkOutput("rstUsr", rd, 32'd0);
    checkOutput("accessReady", 32'(rdy), 32'd1);

    // Reset landing inside a start bit must release tx immediately.
    apbWrite(A_UWD, 32'h55);
    for (int i = 0; i < 10 && tx !== 1'b0; i++) @(negedge PCLK);
    checkOutput("midTxLow", 32'(tx), 32'd0);
    repeat (3) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1 checkOutput("rstAsyncTx", 32'(tx), 32'd1);
    @(negedge PCLK);
    PRESET = 1'b0;
    readCheck("usrAfterRst", A_USR, 32'd0);

    txMonEn = 1'b1;
    txExpQ.push_back(8'hA5);
    apbWrite(A_UWD, 32'h0000_00A5);
    lat = 0;
    while (tx !== 1'b0 && lat < 10) begin
      @(negedge PCLK);
      lat++;
    end
    checkOutput("txLatencyOk", 32'(lat <= 3), 32'd1);
    readCheck("usrTxBusy", A_USR, 32'h4);
    waitTxDrain(400);
    repeat (20) @(negedge PCLK);
    readCheck("usrTxDone", A_USR, 32'h0);

    readCheck("readUwdZero", A_UWD, 32'h0);
    readCheck("readUclrZero", A_UCLR, 32'h0);

    txExpQ.push_back(8'h5A);
    apbWrite(A_UWD, 32'h5A);
    for (int i = 1; i <= 4; i++) begin
      txExpQ.push_back(8'(i));
      apbWrite(A_UWD, 32'(i));
    end
    readCheck("usrTxFull", A_USR, 32'h6);
    apbWrite(A_UWD, 32'h05);
    readCheck("usrTxFullDrop", A_USR, 32'h6);
    waitTxDrain(2000);
    repeat (250) @(negedge PCLK);
    readCheck("usrTxIdle", A_USR, 32'h0);

    applyStimulus(8'h3C, 1'b1);
    repeat (4) @(negedge PCLK);
    readCheck("usrRxValid", A_USR, expUsrRx());
    readRxByte();
    readCheck("usrRxEmpty", A_USR, expUsrRx());
    readCheck("urdEmptyZero", A_URD, 32'h0);

    applyStimulus(8'h77, 1'b0);
    repeat (40) @(negedge PCLK);
    readCheck("usrFramingErr", A_USR, expUsrRx());

    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h55, 1'b1);
    repeat (4) @(negedge PCLK);
    readCheck("usrOverrun", A_USR, expUsrRx());
    apbWrite(A_UCLR, 32'h0);
    readCheck("usrClrBit0Low", A_USR, expUsrRx());
    for (int i = 0; i < FIFO_DEPTH; i++) readRxByte();
    readCheck("usrOverrunDrained", A_USR, expUsrRx());
    apbWrite(A_UCLR, 32'h1);
    expOverrun = 1'b0;
    readCheck("usrOverrunCleared", A_USR, expUsrRx());

    @(negedge PCLK);
    rx = 1'b0;
    repeat (4) @(negedge PCLK);
    rx = 1'b1;
    repeat (40) @(negedge PCLK);
    readCheck("usrGlitch", A_USR, expUsrRx());
    applyStimulus(8'h81, 1'b1);
    repeat (4) @(negedge PCLK);
    readCheck("usrAfterGlitch", A_USR, expUsrRx());
    readRxByte();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
